motion_door_responder: RTL
==========================

MOTION_DOOR_RESPONDER -- requirements
Module: motion_door_responder

Interface
REQ-001 Parameter: OPEN_CYCLES, 96, door-open dwell in clk cycles (3 s at 32 Hz); legal range 2..255.
REQ-002 Parameter: RUN_CYCLES, 64, one-floor travel time in clk cycles (2 s at 32 Hz); legal range 2..255.
REQ-003 clk  input  1  system clock (32 Hz); all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 switch  input  1  elevator master enable; 0 = synchronous clear of all state.
REQ-006 req_btn  input  4  floor call buttons, level, bit0 = floor 1 .. bit3 = floor 4.
REQ-007 opendoor  input  1  door-open command from the state controller.
REQ-008 mv2nxt  input  1  move-one-floor command from the state controller.
REQ-009 position  input  4  one-hot current floor, bit0 = floor 1.
REQ-010 eff_req  output  4  registered pending requests, one bit per floor.
REQ-011 ud_mode  output  2  registered direction: 01 up, 10 down, 00 idle; 11 never driven.
REQ-012 endOpen  output  1  one-cycle pulse: door dwell complete.
REQ-013 endRun  output  1  one-cycle pulse: one-floor travel complete.

Function
REQ-014 Door timer: 8-bit counter, increments each cycle while opendoor=1 and not done; endOpen=1 for exactly one cycle on the cycle after the counter reaches OPEN_CYCLES-1.
REQ-015 After endOpen, the door timer clears to 0 and SHALL NOT count again until opendoor has been sampled 0 for at least one cycle (rearm).
REQ-016 opendoor dropping mid-dwell clears the door counter with no endOpen pulse.
REQ-017 Run timer: same structure with mv2nxt and RUN_CYCLES, producing endRun; same rearm rule and same abort on mv2nxt falling.
REQ-018 Latency: first cycle with command=1 to pulse = exactly OPEN_CYCLES / RUN_CYCLES cycles.
REQ-019 Request register: each cycle eff_req <= (eff_req | req_btn) & ~clr, where clr = position when endOpen is asserted this cycle, else 0.
REQ-020 Simultaneous press and clear on the current floor: clear wins for that cycle; press held on the next cycle sets the bit again.
REQ-021 Direction masks: above = eff_req bits strictly higher than the position bit; below = bits strictly lower; the current-floor bit contributes to neither.
REQ-022 ud_mode next value priority: ud_mode=01 and above!=0 -> 01; ud_mode=10 and below!=0 -> 10; else above!=0 -> 01; else below!=0 -> 10; else 00.
REQ-023 ud_mode SHALL be frozen while mv2nxt=1 or endRun=1, so the controller shifts position in the direction used to start the move.
REQ-024 Non-one-hot position (0000 or multiple bits): ud_mode <= 00, timers still operate, and eff_req is updated with clr = 0.
REQ-025 Boundaries: at floor 4, above=0; at floor 1, below=0; the direction never points off the shaft.
REQ-026 Neither timer counts beyond its terminal value; counters never wrap.

Reset
REQ-027 rst_n=0 asynchronously forces eff_req=0000, ud_mode=00, endOpen=0, endRun=0, both counters=0 and both rearm flags set.
REQ-028 switch=0 on a clock edge forces the same values synchronously and discards button input during that cycle.
REQ-029 Reset asserted mid-dwell or mid-travel aborts the operation with no pulse; the first pulse after release needs the full count.

Verification
REQ-030 Scenario, door dwell: position=0001, req_btn=0001 one cycle, opendoor held 1 -> endOpen high exactly at cycle 96, one cycle wide; eff_req[0] clears that cycle.
REQ-031 Scenario, run: position=0001, eff_req=1000 -> ud_mode=01; mv2nxt held 1 -> endRun at cycle 64, single pulse; no second pulse while mv2nxt stays 1.
REQ-032 Scenario, direction hold: position=0100, ud_mode=01, eff_req=1001 -> ud_mode stays 01; after eff_req[3] clears -> ud_mode=10 next cycle.
REQ-033 Scenario, freeze: mv2nxt=1, ud_mode=10; press only floor above -> ud_mode stays 10 until mv2nxt=0 and endRun=0.
REQ-034 Scenario, abort: opendoor=1 for 50 cycles, then rst_n low 1 cycle -> no endOpen; all outputs 0; new opendoor -> endOpen after full 96 cycles.
REQ-035 Scenario, clear-vs-press: req_btn[1]=1 on the endOpen cycle at position 0010 -> eff_req[1]=0 that cycle; button still held next cycle -> eff_req[1]=1.

Source files
------------

// File: rtl/motion_door_responder.sv
// motion_door_responder: door/travel timers, pending-request register and direction selection for an elevator controller
module motion_door_responder_timer #(
    parameter int CYCLES = 96
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_cmd,
    output logic o_pulse
);
    logic [7:0] r_cnt;
    logic       r_armed;
    logic       w_done;

    // terminal count reached while the command is held and the timer is armed
    always_comb w_done = i_cmd && r_armed && (r_cnt == 8'(CYCLES - 1));

    // counter stops at the terminal value, fires once, then waits for the command to drop before rearming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
            o_pulse <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
            o_pulse <= 1'b0;
        end else begin
            o_pulse <= w_done;
            if (!i_cmd) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_armed <= 1'b0;
            end else if (r_armed) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

module motion_door_responder #(
    parameter int OPEN_CYCLES = 96,
    parameter int RUN_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic [3:0] req_btn,
    input  logic       opendoor,
    input  logic       mv2nxt,
    input  logic [3:0] position,
    output logic [3:0] eff_req,
    output logic [1:0] ud_mode,
    output logic       endOpen,
    output logic       endRun
);
    logic       w_clr_all;
    logic       w_onehot;
    logic [3:0] w_above;
    logic [3:0] w_below;
    logic [3:0] w_clr;
    logic [1:0] w_ud_next;

    assign w_clr_all = !switch;

    motion_door_responder_timer #(.CYCLES(OPEN_CYCLES)) u_open (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr_all),
        .i_cmd  (opendoor),
        .o_pulse(endOpen)
    );

    motion_door_responder_timer #(.CYCLES(RUN_CYCLES)) u_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr_all),
        .i_cmd  (mv2nxt),
        .o_pulse(endRun)
    );

    // floor masks relative to the current floor; direction held during a move, forced idle on a bad position
    always_comb begin
        w_onehot  = (position != 4'd0) && ((position & (position - 4'd1)) == 4'd0);
        w_above   = eff_req & ~((position << 1) - 4'd1);
        w_below   = eff_req & (position - 4'd1);
        w_clr     = (endOpen && w_onehot) ? position : 4'd0;
        w_ud_next = !w_onehot                          ? 2'b00 :
                    (mv2nxt || endRun)                 ? ud_mode :
                    (ud_mode == 2'b01 && w_above != 0) ? 2'b01 :
                    (ud_mode == 2'b10 && w_below != 0) ? 2'b10 :
                    (w_above != 0)                     ? 2'b01 :
                    (w_below != 0)                     ? 2'b10 : 2'b00;
    end

    // pending requests accumulate button presses; the served floor is cleared during the door-done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_req <= '0;
            ud_mode <= 2'b00;
        end else if (w_clr_all) begin
            eff_req <= '0;
            ud_mode <= 2'b00;
        end else begin
            eff_req <= (eff_req | req_btn) & ~w_clr;
            ud_mode <= w_ud_next;
        end
    end
endmodule
